// File: rtl/message_fcs_check.sv
// Store-and-forward frame checker: strips the trailing 32-bit additive FCS,
// releases good frames and drops bad/runt/aborted/overflowing ones by rollback.
module message_fcs_check #(
    parameter int DEPTH_W = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        din_vld,
    output logic [7:0]  dout,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
    output logic [15:0] ovf_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FRAME = 1'b1;
    localparam int         DEPTH   = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] FULL_DIST = {1'b1, {DEPTH_W{1'b0}}};

    logic [9:0]         r_mem [DEPTH];
    logic [0:0]         r_state;
    logic [DEPTH_W:0]   r_wr_ptr;
    logic [DEPTH_W:0]   r_rd_ptr;
    logic [DEPTH_W:0]   r_commit_ptr;
    logic [3:0][7:0]    r_sr;
    logic [2:0]         r_sr_cnt;
    logic [31:0]        r_sum;
    logic               r_sop_flag;
    logic               r_ovf;
    logic [15:0]        r_good_cnt;
    logic [15:0]        r_bad_cnt;
    logic [15:0]        r_ovf_cnt;

    logic               w_sop;
    logic               w_in_byte;
    logic               w_eop;
    logic               w_abort;
    logic               w_sop_runt;
    logic               w_sr_full;
    logic               w_evict;
    logic               w_full;
    logic               w_wr_en;
    logic               w_ovf_now;
    logic [31:0]        w_sum_next;
    logic [31:0]        w_fcs;
    logic               w_fcs_ok;
    logic               w_runt;
    logic               w_good;
    logic               w_ovf_drop;
    logic               w_bad_fcs;
    logic               w_rollback;
    logic [1:0]         w_bad_inc;
    logic               w_rd_en;
    logic [9:0]         w_head;

    function automatic logic [15:0] sat_add(input logic [15:0] c,
                                            input logic [1:0]  inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_sop      = din_vld & din_sop;
    assign w_in_byte  = din_vld & ~din_sop & (r_state == S_FRAME);
    assign w_eop      = w_in_byte & din_eop;
    assign w_abort    = w_sop & (r_state == S_FRAME);
    assign w_sop_runt = w_sop & din_eop;
    assign w_sr_full  = (r_sr_cnt == 3'd4);
    assign w_evict    = w_in_byte & w_sr_full;
    assign w_full     = ((r_wr_ptr - r_rd_ptr) == FULL_DIST);
    assign w_wr_en    = w_evict & ~r_ovf & ~w_full;
    assign w_ovf_now  = r_ovf | (w_evict & w_full);

    // The evicted byte is the last DATA byte at eop, so it joins the sum here.
    assign w_sum_next = r_sum + {24'd0, r_sr[3]};
    assign w_fcs      = {r_sr[2], r_sr[1], r_sr[0], din};
    assign w_fcs_ok   = (w_sum_next == w_fcs);

    assign w_runt     = (w_eop & ~w_sr_full) | w_sop_runt;
    assign w_good     = w_eop & w_sr_full & ~w_ovf_now & w_fcs_ok;
    assign w_ovf_drop = w_eop & w_sr_full & w_ovf_now;
    assign w_bad_fcs  = w_eop & w_sr_full & ~w_ovf_now & ~w_fcs_ok;
    assign w_rollback = w_abort | w_runt | w_ovf_drop | w_bad_fcs;
    assign w_bad_inc  = {1'b0, w_abort} + {1'b0, w_runt | w_bad_fcs};

    assign dout_vld   = (r_rd_ptr != r_commit_ptr);
    assign w_rd_en    = dout_vld & dout_rdy;
    assign w_head     = r_mem[r_rd_ptr[DEPTH_W-1:0]];
    assign dout       = dout_vld ? w_head[7:0] : 8'd0;
    assign dout_eop   = dout_vld & w_head[8];
    assign dout_sop   = dout_vld & w_head[9];

    assign good_cnt   = r_good_cnt;
    assign bad_cnt    = r_bad_cnt;
    assign ovf_cnt    = r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[DEPTH_W-1:0]] <= {r_sop_flag, din_eop, r_sr[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_sr_cnt   <= 3'd0;
            r_sum      <= 32'd0;
            r_sop_flag <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_sop) begin
            r_state    <= din_eop ? S_IDLE : S_FRAME;
            r_sr[0]    <= din;
            r_sr_cnt   <= 3'd1;
            r_sum      <= 32'd0;
            r_sop_flag <= 1'b1;
            r_ovf      <= 1'b0;
        end else if (w_in_byte) begin
            r_sr <= {r_sr[2], r_sr[1], r_sr[0], din};
            if (!w_sr_full) begin
                r_sr_cnt <= r_sr_cnt + 3'd1;
            end
            if (w_evict) begin
                r_sum      <= w_sum_next;
                r_sop_flag <= 1'b0;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end
            end
            if (din_eop) begin
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
        end else begin
            if (w_rollback) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_good) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
            r_ovf_cnt  <= 16'd0;
        end else begin
            r_good_cnt <= sat_add(r_good_cnt, {1'b0, w_good});
            r_bad_cnt  <= sat_add(r_bad_cnt, w_bad_inc);
            r_ovf_cnt  <= sat_add(r_ovf_cnt, {1'b0, w_ovf_drop});
        end
    end

endmodule

// File: tb/tb_message_fcs_check.sv
// Directed bench for message_fcs_check: default-depth and 16-entry instances.
module tb_message_fcs_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_sop, din_eop;
    logic        vld_a, vld_b, rdy;
    logic [7:0]  dout_a, dout_b;
    logic        sop_a, eop_a, dvld_a, sop_b, eop_b, dvld_b;
    logic [15:0] good_a, bad_a, ovf_a, good_b, bad_b, ovf_b;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [9:0]  got_a[$], got_b[$], exp_a[$], exp_b[$];
    logic [7:0]  frm[$];
    bit          tgt_b = 1'b0;

    always #5 clk = ~clk;

    message_fcs_check u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_sop(din_sop),
        .din_eop(din_eop), .din_vld(vld_a), .dout(dout_a),
        .dout_sop(sop_a), .dout_eop(eop_a), .dout_vld(dvld_a),
        .dout_rdy(rdy), .good_cnt(good_a), .bad_cnt(bad_a),
        .ovf_cnt(ovf_a)
    );

    message_fcs_check #(.DEPTH_W(4)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .din(din), .din_sop(din_sop),
        .din_eop(din_eop), .din_vld(vld_b), .dout(dout_b),
        .dout_sop(sop_b), .dout_eop(eop_b), .dout_vld(dvld_b),
        .dout_rdy(rdy), .good_cnt(good_b), .bad_cnt(bad_b),
        .ovf_cnt(ovf_b)
    );

    always @(negedge clk) begin
        if (rst_n && dvld_a && rdy) got_a.push_back({sop_a, eop_a, dout_a});
        if (rst_n && dvld_b && rdy) got_b.push_back({sop_b, eop_b, dout_b});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s,
                             input logic e);
        @(posedge clk); #1;
        din     = b;
        din_sop = s;
        din_eop = e;
        vld_a   = !tgt_b;
        vld_b   = tgt_b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vld_a   = 1'b0;
            vld_b   = 1'b0;
            din_sop = 1'b0;
            din_eop = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] fcs, input bit good);
        int n;
        n = frm.size();
        for (int i = 0; i < n; i++) begin
            send_byte(frm[i], i == 0, 1'b0);
            if (good) begin
                if (tgt_b) exp_b.push_back({i == 0, i == n - 1, frm[i]});
                else       exp_a.push_back({i == 0, i == n - 1, frm[i]});
            end
        end
        for (int k = 0; k < 4; k++) begin
            send_byte(fcs[31-8*k -: 8], 1'b0, k == 3);
        end
    endtask

    task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
        frm = '{8'h01, 8'h00, 8'h03, a, b, c};
    endtask

    task automatic drain(input string tag, input bit b);
        logic [9:0] g[$], e[$];
        int c;
        c = 0;
        while (c < 400 && (b ? got_b.size() < exp_b.size()
                             : got_a.size() < exp_a.size())) begin
            @(posedge clk);
            c++;
        end
        repeat (6) @(posedge clk);
        if (b) begin
            g = got_b; e = exp_b; got_b.delete(); exp_b.delete();
        end else begin
            g = got_a; e = exp_a; got_a.delete(); exp_a.delete();
        end
        chk({tag, "_count"}, g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {22'd0, g[i]},
                {22'd0, e[i]});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        din     = 8'd0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        vld_a   = 1'b0;
        vld_b   = 1'b0;
        rdy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {31'd0, dvld_a}, 32'd0);
        chk("rst_dout", {24'd0, dout_a}, 32'd0);
        chk("rst_sop", {31'd0, sop_a}, 32'd0);
        chk("rst_eop", {31'd0, eop_a}, 32'd0);
        chk("rst_good", {16'd0, good_a}, 32'd0);
        chk("rst_bad", {16'd0, bad_a}, 32'd0);
        chk("rst_ovf", {16'd0, ovf_a}, 32'd0);
        rst_n = 1'b1;

        // control frame: sum(0x01..0x40) = 0x820
        rdy = 1'b1;
        frm.delete();
        for (int i = 0; i <= 64; i++) frm.push_back(8'(i));
        send_frame(32'h0000_0820, 1'b1);
        idle(1);
        drain("ctrl", 1'b0);
        chk("ctrl_good", {16'd0, good_a}, 32'd1);

        set_data(8'hAA, 8'hBB, 8'hCC);
        send_frame(32'h0000_0235, 1'b1);
        idle(1);
        drain("data", 1'b0);
        chk("data_good", {16'd0, good_a}, 32'd2);

        set_data(8'hAA, 8'hBB, 8'hCC);
        send_frame(32'h0000_0236, 1'b0);
        idle(1);
        drain("badfcs", 1'b0);
        chk("badfcs_bad", {16'd0, bad_a}, 32'd1);
        chk("badfcs_good", {16'd0, good_a}, 32'd2);

        // backpressure: two back-to-back frames
        rdy = 1'b0;
        set_data(8'hAA, 8'hBB, 8'hCC);
        send_frame(32'h0000_0235, 1'b1);
        chk("bp_hidden", {31'd0, dvld_a}, 32'd0);
        set_data(8'h11, 8'h22, 8'h33);
        send_frame(32'h0000_006A, 1'b1);
        chk("bp_commit_vld", {31'd0, dvld_a}, 32'd1);
        idle(20);
        chk("bp_held_vld", {31'd0, dvld_a}, 32'd1);
        chk("bp_held_head", {22'd0, sop_a, eop_a, dout_a}, 32'h201);
        chk("bp_no_xfer", got_a.size(), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            rdy = ~rdy;
        end
        rdy = 1'b1;
        drain("bp", 1'b0);
        chk("bp_good", {16'd0, good_a}, 32'd4);

        // runt: 4 bytes sop..eop
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b1);
        idle(2);
        chk("runt_bad", {16'd0, bad_a}, 32'd2);

        // abort after 3 bytes, then a good frame (sum 0x103)
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        set_data(8'h44, 8'h55, 8'h66);
        send_frame(32'h0000_0103, 1'b1);
        idle(1);
        drain("abort", 1'b0);
        chk("abort_bad", {16'd0, bad_a}, 32'd3);
        chk("abort_good", {16'd0, good_a}, 32'd5);

        // overflow on the 16-entry instance: 20 data bytes + FCS 0xBE
        tgt_b = 1'b1;
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'(i));
        send_frame(32'h0000_00BE, 1'b0);
        set_data(8'hAA, 8'hBB, 8'hCC);
        send_frame(32'h0000_0235, 1'b1);
        idle(1);
        drain("ovf", 1'b1);
        chk("ovf_cnt", {16'd0, ovf_b}, 32'd1);
        chk("ovf_good", {16'd0, good_b}, 32'd1);
        chk("ovf_bad", {16'd0, bad_b}, 32'd0);
        tgt_b = 1'b0;

        // reset mid-frame with committed data pending
        rdy = 1'b0;
        set_data(8'hAA, 8'hBB, 8'hCC);
        send_frame(32'h0000_0235, 1'b0);
        idle(2);
        chk("pre_rst_vld", {31'd0, dvld_a}, 32'd1);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        vld_a = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, dvld_a}, 32'd0);
        chk("mid_rst_dout", {24'd0, dout_a}, 32'd0);
        chk("mid_rst_sop", {31'd0, sop_a}, 32'd0);
        chk("mid_rst_good", {16'd0, good_a}, 32'd0);
        chk("mid_rst_bad", {16'd0, bad_a}, 32'd0);
        got_a.delete();
        exp_a.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy   = 1'b1;
        set_data(8'h77, 8'h88, 8'h99);
        send_frame(32'h0000_019C, 1'b1);
        idle(1);
        drain("post_rst", 1'b0);
        chk("post_rst_good", {16'd0, good_a}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/message_fcs_check.md
# message_fcs_check

Store-and-forward frame checker that sits directly downstream of the message identification stage. It accepts that stage's byte stream (TYPE, LEN, DATA, FCS bytes framed by sop/eop/vld) and computes a 32-bit additive checksum over every byte except the trailing 4 FCS bytes. Frames whose checksum matches are released on a valid/ready output with the FCS stripped. Bad, runt, aborted and overflowing frames are dropped by write-pointer rollback and counted.

## Interface
- `DEPTH_W`, default 11: log2 of the frame buffer depth in bytes (2048 entries, each entry 10 bits: {sop, eop, byte}).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  8  input byte from the identification stage.
- `din_sop`  in  1  first byte of a frame (TYPE); sampled only when `din_vld`=1.
- `din_eop`  in  1  last byte of a frame (last FCS byte); sampled only when `din_vld`=1.
- `din_vld`  in  1  input byte valid; there is no backpressure, so every valid byte is accepted.
- `dout`  out  8  output byte, TYPE/LEN/DATA only.
- `dout_sop`  out  1  first byte of a released frame.
- `dout_eop`  out  1  last DATA byte of a released frame.
- `dout_vld`  out  1  committed byte available at the FIFO head.
- `dout_rdy`  in  1  consumer ready; a transfer occurs when `dout_vld`&&`dout_rdy`.
- `good_cnt`  out  16  frames released; saturates at 0xFFFF.
- `bad_cnt`  out  16  FCS mismatch, runt or aborted frames; saturates at 0xFFFF.
- `ovf_cnt`  out  16  frames dropped for buffer overflow; saturates at 0xFFFF.

## Operation
- Input FSM has 2 states: IDLE and FRAME.
  - IDLE → FRAME on `din_vld`&&`din_sop`.
  - FRAME → IDLE on `din_vld`&&`din_eop`.
  - In IDLE, valid bytes without sop are ignored.
- On a sop byte:
  - Clear `sum`, `sr_cnt` and the ovf flag.
  - Load the byte into the 4-byte shift register `sr[0]`.
  - Mark the first evicted byte of the frame as sop.
- Shift register `sr[3:0]` delays bytes by 4. On each valid in-frame byte with `sr_cnt`==4:
  - Evict `sr[3]`.
  - Write `{sop_flag, eop_now, sr[3]}` to the FIFO at `wr_ptr`.
  - Update `sum` = `sum` + `sr[3]`, modulo 2^32.
  - Shift the incoming byte in.
- At eop with `sr_cnt`==4:
  - The evicted byte is the last DATA byte and is written with eop=1.
  - FCS = {`sr[2]`, `sr[1]`, `sr[0]`, `din`}, big-endian, first FCS byte is the MSB.
  - Check `sum` + evicted byte == FCS.
- Commit decision, taken at the eop edge:
  - Check passes and no overflow: `commit_ptr` ← `wr_ptr`+1, `good_cnt`++.
  - Overflow flag set: `wr_ptr` ← `commit_ptr`, `ovf_cnt`++. The FCS is not checked.
  - Otherwise: `wr_ptr` ← `commit_ptr`, `bad_cnt`++.
- Runt: eop with fewer than 5 bytes in the frame (`sr_cnt`<4 at eop, including sop and eop on the same byte) → rollback, `bad_cnt`++.
- Abort: sop while in FRAME → roll back the partial frame, `bad_cnt`++, then start the new frame with this byte.
- Full: `wr_ptr` − `rd_ptr` == 2^`DEPTH_W` (pointers are `DEPTH_W`+1 bits).
  - A write attempted while full is discarded and sets the ovf flag.
  - The rest of the frame keeps being consumed but nothing further is written.
- Read side:
  - `dout_vld` = (`rd_ptr` != `commit_ptr`).
  - `dout`, `dout_sop` and `dout_eop` come from the FIFO head entry.
  - `rd_ptr`++ on transfer.
  - Uncommitted bytes are never visible.
- All counter increments saturate. Reads and writes in the same cycle are legal.

## Timing
- Reset values: `dout`=0, `dout_sop`=0, `dout_eop`=0, `dout_vld`=0, all counters 0. Also all pointers 0, FSM in IDLE, `sum`=0, `sr_cnt`=0.
- Reset asserted mid-frame discards everything, committed data included.
- Input throughput: 1 byte per `din_vld` cycle, with arbitrary vld gaps.
- Commit latency: eop sampled at edge T → `commit_ptr` and counters update at edge T. `dout_vld` rises in the cycle after T, if the FIFO was previously empty.
- Output throughput: 1 byte per cycle while `dout_rdy`=1. With `dout_rdy`=0, the head entry holds stable.
- Same-cycle rollback and read: the read uses the pre-edge `commit_ptr`. A rollback never moves `wr_ptr` below `commit_ptr`.

## Test plan
- Control frame:
  - Stimulus: TYPE 0x00, data 0x01..0x40 (64 bytes), FCS 0x00000820, `dout_rdy`=1.
  - Response: 65 output bytes; sop on 0x00, eop on 0x40; `good_cnt`=1.
- Data frame:
  - Stimulus: 01 00 03 AA BB CC, FCS 0x00000235.
  - Response: 6 bytes out, sop on 0x01, eop on 0xCC.
  - Repeat with FCS 0x00000236 → no output, `bad_cnt`=1.
- Backpressure:
  - Stimulus: two back-to-back good data frames with `dout_rdy` low for 20 cycles, then toggling 1/0.
  - Response: 12 bytes out in order, correct sop/eop, no duplicates or losses.
- Runt and abort:
  - Runt stimulus: a 4-byte frame (sop..eop). Abort stimulus: a frame interrupted by a new sop after 3 bytes, followed by a good frame.
  - Response: `bad_cnt`=2 and only the good frame appears on the output.
- Overflow:
  - Stimulus: `DEPTH_W`=4; a 24-byte frame, then a good 6-byte data frame.
  - Response: `ovf_cnt`=1; the data frame is released intact.
- Reset:
  - Stimulus: `rst_n` pulsed low mid-frame while committed data is pending.
  - Response: all outputs 0 immediately, `dout_vld`=0; the next good frame passes.
